// File: rtl/vsd_spi_router.sv
// SPI router between the core's SD SPI master, up to four virtual sd_card drives
// and the physical SD slot, plus activity LED stretcher and mount-driven hard reset.
module vsd_spi_router #(
  parameter int NUM_DRIVES   = 2,
  parameter int PHYS_DRIVE   = 0,
  parameter int ACT_CYCLES   = 1000000,
  parameter int HWRST_CYCLES = 65535
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [NUM_DRIVES-1:0] img_mounted,
  input  logic                  img_size_nz,
  input  logic [NUM_DRIVES-1:0] rst_on_mount,
  input  logic                  hard_reset_req,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  input  logic [NUM_DRIVES-1:0] spi_ss_n,
  output logic                  spi_miso,
  output logic [NUM_DRIVES-1:0] vsd_ss_n,
  input  logic [NUM_DRIVES-1:0] vsd_miso,
  output logic                  SD_CS,
  output logic                  SD_SCK,
  output logic                  SD_MOSI,
  input  logic                  SD_MISO,
  output logic [NUM_DRIVES-1:0] vsd_sel,
  output logic                  sd_act,
  output logic                  hw_reset
);

  localparam int ACT_W = $clog2(ACT_CYCLES + 1);
  localparam int RST_W = $clog2(HWRST_CYCLES + 1);
  localparam logic [ACT_W-1:0] ACT_MAX  = ACT_W'(ACT_CYCLES);
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(HWRST_CYCLES);

  logic [NUM_DRIVES-1:0] pend;
  logic                  sck_d;
  logic [ACT_W-1:0]      act_cnt;
  logic [RST_W-1:0]      rst_cnt;
  logic                  any_ss;
  logic                  sck_toggle;
  logic                  trigger;

  // Selection: a mount only takes effect while that drive's chip select is idle,
  // so a transfer in flight never sees the backing store switch underneath it.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pend    <= '0;
      vsd_sel <= '0;
    end else begin
      for (int i = 0; i < NUM_DRIVES; i++) begin
        if (img_mounted[i])
          pend[i] <= img_size_nz;
        if (spi_ss_n[i])
          vsd_sel[i] <= img_mounted[i] ? img_size_nz : pend[i];
      end
    end
  end

  assign vsd_ss_n = spi_ss_n | ~vsd_sel;
  assign SD_CS    = spi_ss_n[PHYS_DRIVE] | vsd_sel[PHYS_DRIVE];
  assign SD_SCK   = spi_sck & ~vsd_sel[PHYS_DRIVE];
  assign SD_MOSI  = spi_mosi | vsd_sel[PHYS_DRIVE];

  // Walk from the top so the lowest asserted select ends up owning MISO.
  always_comb begin
    spi_miso = 1'b1;
    for (int i = NUM_DRIVES - 1; i >= 0; i--) begin
      if (!spi_ss_n[i]) begin
        if (vsd_sel[i])
          spi_miso = vsd_miso[i];
        else if (i == PHYS_DRIVE)
          spi_miso = SD_MISO;
        else
          spi_miso = 1'b1;
      end
    end
  end

  assign any_ss     = ~&spi_ss_n;
  assign sck_toggle = (spi_sck != sck_d) && any_ss;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sck_d   <= 1'b0;
      act_cnt <= ACT_MAX;
      sd_act  <= 1'b0;
    end else begin
      sck_d <= spi_sck;
      if (sck_toggle)
        act_cnt <= '0;
      else if (act_cnt != ACT_MAX)
        act_cnt <= act_cnt + 1'b1;
      sd_act <= (act_cnt < ACT_MAX);
    end
  end

  assign trigger = hard_reset_req | (|(img_mounted & rst_on_mount));

  // hw_reset looks at the pre-edge count, giving HWRST_CYCLES+1 cycles per trigger.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt  <= '0;
      hw_reset <= 1'b0;
    end else begin
      if (trigger)
        rst_cnt <= RST_LOAD;
      else if (rst_cnt != '0)
        rst_cnt <= rst_cnt - 1'b1;
      hw_reset <= trigger | (rst_cnt != '0);
    end
  end

endmodule
